// File: rtl/fmap_streamer.sv
// Streams a channel-interleaved feature map from a synchronous buffer as vsync/hsync/reuse/valid frames.
// Define FMAP_STREAMER_HOLD_EN to let i_hold stretch the last gap cycle of each channel group.
module fmap_streamer #(
  parameter int WIDTH_D   = 27,
  parameter int SIZE_C    = 512,
  parameter int SIZE_H    = 7,
  parameter int SIZE_W    = 7,
  parameter int GAP       = 2,
  parameter int FRAME_GAP = 516,
  parameter int ADDR_W    = 15
) (
  input  logic                      i_sclk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic                      i_hold,
  output logic                      o_rd_en,
  output logic [ADDR_W-1:0]         o_rd_addr,
  input  logic signed [WIDTH_D-1:0] i_rd_data,
  output logic                      o_vsync,
  output logic                      o_hsync,
  output logic                      o_reuse,
  output logic                      o_valid,
  output logic signed [WIDTH_D-1:0] o_tdata,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CNT_MAX = (FRAME_GAP > SIZE_W) ? ((FRAME_GAP > GAP) ? FRAME_GAP : GAP)
                                                : ((SIZE_W > GAP) ? SIZE_W : GAP);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int CH_W  = $clog2(SIZE_C + 1);
  localparam int ROW_W = $clog2(SIZE_H + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE_C * SIZE_H * SIZE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_FGAP, S_HSYNC, S_REUSE, S_BURST, S_GAP, S_DONE
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [CH_W-1:0]           ch;
  logic [ROW_W-1:0]          row;
  logic signed [WIDTH_D-1:0] tdata_p1;
  logic                      stall;

`ifdef FMAP_STREAMER_HOLD_EN
  assign stall = i_hold;
`else
  logic hold_unused;
  assign stall       = 1'b0;
  assign hold_unused = i_hold;
`endif

  // Outputs are registered with the state they belong to, so each is set on entry to its state.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch        <= '0;
      row       <= '0;
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      o_vsync   <= 1'b0;
      o_hsync   <= 1'b0;
      o_reuse   <= 1'b0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_reuse <= 1'b0;
      o_done  <= 1'b0;
      o_valid <= o_rd_en;
      // The address saturates at the last index; only VSYNC brings it back to zero.
      if (o_rd_en && (o_rd_addr != LAST_ADDR)) o_rd_addr <= o_rd_addr + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_VSYNC;
            o_vsync <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        S_VSYNC: begin
          o_rd_addr <= '0;
          ch        <= '0;
          row       <= '0;
          cnt       <= '0;
          state     <= S_FGAP;
        end
        S_FGAP: begin
          if (cnt == CNT_W'(FRAME_GAP - 1)) begin
            cnt     <= '0;
            state   <= S_HSYNC;
            o_hsync <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HSYNC: begin
          state   <= S_REUSE;
          o_reuse <= 1'b1;
        end
        S_REUSE: begin
          cnt     <= '0;
          state   <= S_BURST;
          o_rd_en <= 1'b1;
        end
        S_BURST: begin
          if (cnt == CNT_W'(SIZE_W - 1)) begin
            cnt     <= '0;
            state   <= S_GAP;
            o_rd_en <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt != CNT_W'(GAP)) begin
            cnt <= cnt + 1'b1;
          end else if (!stall) begin
            cnt <= '0;
            if (ch == CH_W'(SIZE_C - 1)) begin
              ch <= '0;
              if (row == ROW_W'(SIZE_H - 1)) begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end else begin
                row     <= row + 1'b1;
                state   <= S_HSYNC;
                o_hsync <= 1'b1;
              end
            end else begin
              ch      <= ch + 1'b1;
              state   <= S_REUSE;
              o_reuse <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data stage: pass buffer data through while valid, otherwise hold the last pixel.
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) tdata_p1 <= '0;
    else if (o_valid) tdata_p1 <= i_rd_data;
  end

  assign o_tdata = o_valid ? i_rd_data : tdata_p1;

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer: small 2x2x3 frame cycle-by-cycle plus a default-size frame count.
module tb_fmap_streamer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int errs = 0;

`ifdef FMAP_STREAMER_HOLD_EN
  localparam int HOLD_SH = 5;
`else
  localparam int HOLD_SH = 0;
`endif

  // small instance
  logic               start_s = 1'b0, hold_s = 1'b0;
  logic               rd_en_s, vs_s, hs_s, ru_s, vl_s, bs_s, dn_s;
  logic [7:0]         rd_addr_s;
  logic signed [26:0] rd_data_s = '0, td_s;

  fmap_streamer #(.WIDTH_D(27), .SIZE_C(2), .SIZE_H(2), .SIZE_W(3), .GAP(2),
                  .FRAME_GAP(4), .ADDR_W(8)) dut_s (
    .i_sclk(clk), .i_rstn(rstn), .i_start(start_s), .i_hold(hold_s),
    .o_rd_en(rd_en_s), .o_rd_addr(rd_addr_s), .i_rd_data(rd_data_s),
    .o_vsync(vs_s), .o_hsync(hs_s), .o_reuse(ru_s), .o_valid(vl_s),
    .o_tdata(td_s), .o_busy(bs_s), .o_done(dn_s));

  always @(posedge clk) if (rd_en_s) rd_data_s <= 27'(int'(rd_addr_s) + 100);

  // default-size instance
  logic               start_b = 1'b0, hold_b = 1'b0;
  logic               rd_en_b, vs_b, hs_b, ru_b, vl_b, bs_b, dn_b;
  logic [14:0]        rd_addr_b;
  logic signed [26:0] rd_data_b = '0, td_b;

  fmap_streamer dut_b (
    .i_sclk(clk), .i_rstn(rstn), .i_start(start_b), .i_hold(hold_b),
    .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b),
    .o_vsync(vs_b), .o_hsync(hs_b), .o_reuse(ru_b), .o_valid(vl_b),
    .o_tdata(td_b), .o_busy(bs_b), .o_done(dn_b));

  always @(posedge clk) if (rd_en_b) rd_data_b <= 27'(int'(rd_addr_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int vcyc[12] = '{9, 10, 11, 16, 17, 18, 24, 25, 26, 31, 32, 33};

  function automatic int vidx(input int b);
    for (int i = 0; i < 12; i++) if (vcyc[i] == b) return i;
    return -1;
  endfunction

  function automatic int shifted(input int c, input int sh);
    if (c >= 14 && c < 14 + sh) return -1;
    return (c >= 14 + sh) ? c - sh : c;
  endfunction

  // {vsync, hsync, reuse, valid, done, busy}
  function automatic logic [5:0] exp_flags(input int c, input bit held, input int sh);
    int b;
    logic [5:0] f;
    b = shifted(c, sh);
    if (b < 0) return 6'b000001;
    f[5] = (b == 1) || (held && b == 38);
    f[4] = (b == 6) || (b == 21) || (held && b == 43);
    f[3] = (b == 7) || (b == 14) || (b == 22) || (b == 29) || (held && b == 44);
    f[2] = (vidx(b) >= 0) || (held && b >= 46);
    f[1] = (b == 36);
    f[0] = (b >= 1 && b <= 36) || (held && b >= 38);
    return f;
  endfunction

  task automatic run_frame(input string nm, input bit held, input int extra, input bit hold_on);
    int sh;
    int b;
    sh = hold_on ? HOLD_SH : 0;
    start_s = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (!held) start_s = (c == extra);
      hold_s = hold_on && (c >= 13) && (c <= 17);
      chk($sformatf("%s flags c%0d", nm, c), {vs_s, hs_s, ru_s, vl_s, dn_s, bs_s},
          exp_flags(c, held, sh));
      b = shifted(c, sh);
      if (b >= 0 && vidx(b) >= 0 && !(held && b >= 46))
        chk($sformatf("%s data c%0d", nm, c), td_s, 100 + vidx(b));
      if (c == 12) chk($sformatf("%s tdata hold", nm), td_s, 102);
      if (held && c == 37) chk($sformatf("%s addr sat", nm), rd_addr_s, 11);
      if (held && c == 39) chk($sformatf("%s addr restart", nm), rd_addr_s, 0);
      if (held && c == 45) chk($sformatf("%s rd_en restart", nm), {rd_en_s, rd_addr_s}, {1'b1, 8'd0});
      if (!held && c == 46) chk($sformatf("%s addr end", nm), rd_addr_s, 11);
    end
    start_s = 1'b0;
    hold_s  = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  int nv, nr, nh, nd, bad, lowcnt, last_addr;
  bit prev_hs, done_seen;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset flags s", {vs_s, hs_s, ru_s, vl_s, dn_s, bs_s, rd_en_s}, 0);
    chk("reset addr/data s", {rd_addr_s, td_s}, 0);
    chk("reset flags b", {vs_b, hs_b, ru_b, vl_b, dn_b, bs_b, rd_en_b, rd_addr_b}, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_frame("base", 1'b0, -1, 1'b0);
    run_frame("ign_start", 1'b0, 3, 1'b0);
    run_frame("hold", 1'b0, -1, 1'b1);
    run_frame("held_start", 1'b1, -1, 1'b0);
    do_reset();

    // abort mid-burst
    start_s = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_s = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("pre-abort valid", {vl_s, td_s}, {1'b1, 27'sd101});
    #1 rstn = 1'b0;
    #1;
    chk("abort flags", {vs_s, hs_s, ru_s, vl_s, dn_s, bs_s, rd_en_s}, 0);
    chk("abort addr/data", {rd_addr_s, td_s}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dn_s || bs_s) nd++;
    end
    chk("abort no done/busy", nd, 0);
    run_frame("after_abort", 1'b0, -1, 1'b0);

    // default-size frame
    nv = 0; nr = 0; nh = 0; nd = 0; bad = 0; lowcnt = 0; last_addr = -1;
    prev_hs = 1'b0; done_seen = 1'b0;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      if (vl_b) nv++;
      if (rd_en_b) last_addr = int'(rd_addr_b);
      if (ru_b) begin
        nr++;
        if (!prev_hs && lowcnt != 2) bad++;
      end
      if (hs_b) begin
        if (nh > 0 && lowcnt != 2) bad++;
        nh++;
      end
      if ((vs_b && hs_b) || (hs_b && ru_b) || (ru_b && vl_b) || (vs_b && vl_b)) bad++;
      if (dn_b) begin
        if (lowcnt != 2) bad++;
        done_seen = 1'b1;
        break;
      end
      lowcnt  = vl_b ? 0 : lowcnt + 1;
      prev_hs = hs_b;
      @(negedge clk);
    end
    chk("big done seen", done_seen, 1);
    chk("big valid count", nv, 25088);
    chk("big last addr", last_addr, 25087);
    chk("big reuse count", nr, 3584);
    chk("big hsync count", nh, 7);
    chk("big gap violations", bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
